// File: rtl/fft8_frame_sequencer.sv
// Ping-pong 8-sample frame buffer feeding an FFT engine.
// Start/done/result handshake, WAIT timeout abort, sticky error flags.
module fft8_frame_sequencer #(
    parameter int SAMPLE_W = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [SAMPLE_W-1:0]   Sample_In,
    input  logic                  Sample_Valid,
    output logic                  Sample_Ready,
    output logic [8*SAMPLE_W-1:0] Fft_X,
    output logic                  Fft_Start,
    input  logic                  Fft_Done,
    output logic                  Res_Valid,
    input  logic                  Res_Ack,
    output logic [7:0]            Frame_Count,
    output logic                  Overrun,
    output logic                  Fft_Timeout,
    input  logic                  Clr_Flags
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESULT
    } state_t;

    state_t                           state_q;
    logic [1:0]                       full_q;
    logic [1:0]                       full_d;
    logic                             wr_bank_q;
    logic [2:0]                       wr_idx_q;
    logic                             rd_bank_q;
    logic [CNT_W-1:0]                 cnt_q;
    logic                             start_q;
    logic                             res_valid_q;
    logic [7:0]                       frame_cnt_q;
    logic                             overrun_q;
    logic                             timeout_q;
    logic [7:0][SAMPLE_W-1:0]         bank_q [2];

    logic wr_en;
    logic wr_last;
    logic fill_rd;
    logic abort;
    logic free_en;
    logic drop;

    always_comb begin
        wr_en   = Sample_Valid && !full_q[wr_bank_q];
        drop    = Sample_Valid && full_q[wr_bank_q];
        wr_last = wr_en && (wr_idx_q == 3'd7);
        fill_rd = wr_last && (wr_bank_q == rd_bank_q);
        abort   = (state_q == WAIT) && !Fft_Done && (cnt_q == CNT_LAST);
        free_en = abort || ((state_q == RESULT) && Res_Ack);
        // Free and fill always target different banks, so both can land.
        full_d  = full_q;
        if (free_en) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            bank_q[wr_bank_q][wr_idx_q] <= Sample_In;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            full_q      <= 2'b00;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= 3'd0;
            rd_bank_q   <= 1'b0;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            frame_cnt_q <= 8'd0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            full_q  <= full_d;
            start_q <= 1'b0;
            if (wr_en) begin
                wr_idx_q <= wr_idx_q + 3'd1;
            end
            if (wr_last) begin
                wr_bank_q <= ~wr_bank_q;
            end
            if (free_en) begin
                rd_bank_q <= ~rd_bank_q;
            end
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (Clr_Flags) begin
                overrun_q <= 1'b0;
            end
            if (abort) begin
                timeout_q <= 1'b1;
            end else if (Clr_Flags) begin
                timeout_q <= 1'b0;
            end
            // Completing a frame into the read bank starts the FFT at once.
            unique case (state_q)
                IDLE: begin
                    if (full_q[rd_bank_q] || fill_rd) begin
                        state_q <= START;
                        start_q <= 1'b1;
                    end
                end
                START: begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                end
                WAIT: begin
                    if (Fft_Done) begin
                        state_q     <= RESULT;
                        res_valid_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESULT: begin
                    if (Res_Ack) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Sample_Ready = ~full_q[wr_bank_q];
    assign Fft_X        = bank_q[rd_bank_q];
    assign Fft_Start    = start_q;
    assign Res_Valid    = res_valid_q;
    assign Frame_Count  = frame_cnt_q;
    assign Overrun      = overrun_q;
    assign Fft_Timeout  = timeout_q;

endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// Self-checking bench for fft8_frame_sequencer.
// Vector table of frames plus hand-written corner sequences.
module tb_fft8_frame_sequencer;

    localparam int W  = 16;
    localparam int TO = 64;

    logic           Clk = 1'b0;
    logic           Rst_n = 1'b0;
    logic [W-1:0]   Sample_In = '0;
    logic           Sample_Valid = 1'b0;
    logic           Sample_Ready;
    logic [8*W-1:0] Fft_X;
    logic           Fft_Start;
    logic           Fft_Done = 1'b0;
    logic           Res_Valid;
    logic           Res_Ack = 1'b0;
    logic [7:0]     Frame_Count;
    logic           Overrun;
    logic           Fft_Timeout;
    logic           Clr_Flags = 1'b0;

    fft8_frame_sequencer #(
        .SAMPLE_W(W),
        .TIMEOUT (TO)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Sample_In   (Sample_In),
        .Sample_Valid(Sample_Valid),
        .Sample_Ready(Sample_Ready),
        .Fft_X       (Fft_X),
        .Fft_Start   (Fft_Start),
        .Fft_Done    (Fft_Done),
        .Res_Valid   (Res_Valid),
        .Res_Ack     (Res_Ack),
        .Frame_Count (Frame_Count),
        .Overrun     (Overrun),
        .Fft_Timeout (Fft_Timeout),
        .Clr_Flags   (Clr_Flags)
    );

    always #5 Clk = ~Clk;

    int             n_tests = 0;
    int             n_fail = 0;
    logic [8*W-1:0] exp_q[$];
    logic [8*W-1:0] last_frame = '0;

    typedef struct {
        logic [W-1:0] base;
        logic [W-1:0] stp;
        int           dd;
        int           ad;
        logic [7:0]   cnt;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (Rst_n && Fft_Start) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL start_unexpected: got Fft_X %0h, no frame queued",
                         Fft_X);
            end else begin
                last_frame = exp_q.pop_front();
                chk("fft_x", Fft_X, last_frame);
            end
        end
    end

    task automatic wait_start(input int budget);
        int n = 0;
        while (!Fft_Start && n < budget) begin
            step();
            n++;
        end
        chk("start_seen", Fft_Start, 1'b1);
    endtask

    task automatic run_frame(input logic [W-1:0] base, input logic [W-1:0] stp,
                             input int dd, input int ad);
        logic [8*W-1:0] f;
        Sample_Valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Sample_In = base + stp * W'(i);
            f[i*W +: W] = Sample_In;
            if (i == 7) exp_q.push_back(f);
            step();
        end
        Sample_Valid = 1'b0;
        chk("start_pulse", Fft_Start, 1'b1);
        step();
        chk("start_width", Fft_Start, 1'b0);
        repeat (dd) step();
        Fft_Done = 1'b1;
        step();
        Fft_Done = 1'b0;
        chk("res_valid", Res_Valid, 1'b1);
        for (int k = 0; k < ad; k++) begin
            chk("x_hold", Fft_X, last_frame);
            step();
        end
        Res_Ack = 1'b1;
        chk("res_valid_ack", Res_Valid, 1'b1);
        step();
        Res_Ack = 1'b0;
        chk("res_drop", Res_Valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        logic [8*W-1:0] f;
        tbl[0] = '{16'd1,      16'd1,      3,  0, 8'd1};
        tbl[1] = '{16'h8000,   16'h1111,   0,  2, 8'd2};
        tbl[2] = '{16'hFFFF,   16'hFFFF,   10, 5, 8'd3};
        tbl[3] = '{16'h1234,   16'h0101,   1,  0, 8'd4};

        #12;
        chk("rst_ready", Sample_Ready, 1'b1);
        chk("rst_start", Fft_Start, 1'b0);
        chk("rst_resv", Res_Valid, 1'b0);
        chk("rst_count", Frame_Count, 8'd0);
        chk("rst_ovr", Overrun, 1'b0);
        chk("rst_to", Fft_Timeout, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;
        step();

        for (int v = 0; v < 4; v++) begin
            run_frame(tbl[v].base, tbl[v].stp, tbl[v].dd, tbl[v].ad);
            chk("frame_count", Frame_Count, tbl[v].cnt);
        end

        // 24-sample stream, no done: overrun then timeout
        Sample_Valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            Sample_In = W'(100 + i);
            f[(i % 8)*W +: W] = Sample_In;
            if (i == 7 || i == 15) exp_q.push_back(f);
            step();
            if (i == 15) begin
                chk("ready_low", Sample_Ready, 1'b0);
                chk("ovr_clear", Overrun, 1'b0);
            end
            if (i == 16) chk("ovr_set", Overrun, 1'b1);
        end
        Sample_Valid = 1'b0;
        repeat (48) step();
        chk("to_early", Fft_Timeout, 1'b0);
        step();
        chk("to_set", Fft_Timeout, 1'b1);
        chk("to_ready", Sample_Ready, 1'b1);
        chk("to_count", Frame_Count, 8'd4);
        wait_start(5);
        step();
        Fft_Done = 1'b1;
        step();
        Fft_Done = 1'b0;
        chk("to2_resv", Res_Valid, 1'b1);
        Res_Ack = 1'b1;
        step();
        Res_Ack = 1'b0;
        chk("to2_count", Frame_Count, 8'd5);
        Clr_Flags = 1'b1;
        step();
        Clr_Flags = 1'b0;
        chk("clr_ovr", Overrun, 1'b0);
        chk("clr_to", Fft_Timeout, 1'b0);

        // Held ack while the second bank fills
        Sample_Valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Sample_In = W'(200 + i);
            f[i*W +: W] = Sample_In;
            if (i == 7) exp_q.push_back(f);
            step();
        end
        Sample_Valid = 1'b0;
        chk("a_start", Fft_Start, 1'b1);
        step();
        Fft_Done = 1'b1;
        step();
        Fft_Done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            Sample_Valid = (k < 8);
            if (k < 8) begin
                Sample_In = W'(300 + k);
                f[k*W +: W] = Sample_In;
                if (k == 7) exp_q.push_back(f);
            end
            step();
            chk("hold_resv", Res_Valid, 1'b1);
            chk("hold_x", Fft_X, last_frame);
            chk("hold_nostart", Fft_Start, 1'b0);
        end
        Sample_Valid = 1'b0;
        chk("b_ready_low", Sample_Ready, 1'b0);
        Res_Ack = 1'b1;
        step();
        Res_Ack = 1'b0;
        chk("b_idle", Fft_Start, 1'b0);
        chk("a_count", Frame_Count, 8'd6);
        step();
        chk("b_start", Fft_Start, 1'b1);
        step();
        Fft_Done = 1'b1;
        step();
        Fft_Done = 1'b0;
        Res_Ack = 1'b1;
        step();
        Res_Ack = 1'b0;
        chk("b_count", Frame_Count, 8'd7);

        // Done ignored in IDLE and START; clear vs new overrun
        Fft_Done = 1'b1;
        step();
        Fft_Done = 1'b0;
        step();
        chk("done_idle", Res_Valid, 1'b0);
        chk("done_idle_st", Fft_Start, 1'b0);
        Sample_Valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Sample_In = W'(400 + i);
            f[i*W +: W] = Sample_In;
            if (i == 7) exp_q.push_back(f);
            step();
        end
        Sample_Valid = 1'b0;
        chk("c1_start", Fft_Start, 1'b1);
        Fft_Done = 1'b1;
        step();
        Fft_Done = 1'b0;
        chk("done_start", Res_Valid, 1'b0);
        step();
        chk("done_start2", Res_Valid, 1'b0);
        Sample_Valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Sample_In = W'(450 + i);
            f[i*W +: W] = Sample_In;
            if (i == 7) exp_q.push_back(f);
            step();
        end
        chk("c2_ready_low", Sample_Ready, 1'b0);
        Clr_Flags = 1'b1;
        step();
        Sample_Valid = 1'b0;
        Clr_Flags = 1'b0;
        chk("clr_vs_set", Overrun, 1'b1);
        Clr_Flags = 1'b1;
        step();
        Clr_Flags = 1'b0;
        chk("clr_alone", Overrun, 1'b0);
        Fft_Done = 1'b1;
        step();
        Fft_Done = 1'b0;
        chk("c1_resv", Res_Valid, 1'b1);
        Res_Ack = 1'b1;
        step();
        Res_Ack = 1'b0;
        chk("c1_count", Frame_Count, 8'd8);
        wait_start(5);
        step();
        Fft_Done = 1'b1;
        step();
        Fft_Done = 1'b0;
        Res_Ack = 1'b1;
        step();
        Res_Ack = 1'b0;
        chk("c2_count", Frame_Count, 8'd9);

        // Reset mid-WAIT with a partial frame buffered
        Sample_Valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Sample_In = W'(500 + i);
            f[i*W +: W] = Sample_In;
            if (i == 7) exp_q.push_back(f);
            step();
        end
        chk("d_start", Fft_Start, 1'b1);
        for (int i = 0; i < 3; i++) begin
            Sample_In = W'(600 + i);
            step();
        end
        Sample_Valid = 1'b0;
        Rst_n = 1'b0;
        #2;
        chk("arst_ready", Sample_Ready, 1'b1);
        chk("arst_start", Fft_Start, 1'b0);
        chk("arst_resv", Res_Valid, 1'b0);
        chk("arst_count", Frame_Count, 8'd0);
        chk("arst_ovr", Overrun, 1'b0);
        chk("arst_to", Fft_Timeout, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;
        step();
        run_frame(16'h0A00, 16'h0011, 1, 0);
        chk("e_count", Frame_Count, 8'd1);

        // Frame counter wrap
        for (int i = 0; i < 255; i++) begin
            run_frame(W'(i * 8), W'(3), 0, 0);
            if (i == 253) chk("count_255", Frame_Count, 8'd255);
        end
        chk("count_wrap", Frame_Count, 8'd0);

        step();
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft8_frame_sequencer.md
FFT8_FRAME_SEQUENCER -- requirements
Module: fft8_frame_sequencer

Interface
REQ-001 The block SHALL have these parameters: SAMPLE_W, 16, sample width in bits; TIMEOUT, 64, maximum cycles to wait for Fft_Done before aborting a frame.
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Sample_In  input  SAMPLE_W  incoming audio sample.
REQ-005 Sample_Valid  input  1  Sample_In is valid this cycle.
REQ-006 Sample_Ready  output  1  block can accept a sample this cycle.
REQ-007 Fft_X  output  8*SAMPLE_W  frame to the FFT; X0 at [SAMPLE_W-1:0] ... X7 in the top SAMPLE_W bits.
REQ-008 Fft_Start  output  1  one-cycle pulse; Fft_X is a valid frame.
REQ-009 Fft_Done  input  1  FFT result available.
REQ-010 Res_Valid  output  1  FFT result for the current frame is ready downstream.
REQ-011 Res_Ack  input  1  downstream consumed the result.
REQ-012 Frame_Count  output  8  count of completed (acknowledged) frames.
REQ-013 Overrun  output  1  sticky: a sample was offered while Sample_Ready was low.
REQ-014 Fft_Timeout  output  1  sticky: a frame was aborted on timeout.
REQ-015 Clr_Flags  input  1  clears Overrun and Fft_Timeout.

Function
REQ-016 Storage SHALL be two banks of 8 samples (ping-pong), each bank with a full flag, plus a write bank pointer, 3-bit write index, and read bank pointer.
REQ-017 Sample_Ready SHALL equal NOT full[write bank], derived from registers only.
REQ-018 On Sample_Valid AND Sample_Ready, the sample SHALL be written to entry write-index of the write bank; the index then increments.
REQ-019 When entry 7 is written, the index SHALL wrap to 0, that bank's full flag SHALL set, and the write bank pointer SHALL toggle, all on the same edge.
REQ-020 Sample_Valid with Sample_Ready low SHALL drop the sample and set Overrun.
REQ-021 The FSM SHALL have states IDLE, START, WAIT, RESULT.
REQ-022 IDLE->START when full[read bank] is set; START lasts exactly one cycle with Fft_Start=1, then ->WAIT.
REQ-023 Fft_Start asserts in the cycle immediately after the edge on which the 8th sample of a frame is accepted, if the FSM is in IDLE.
REQ-024 Fft_X SHALL always present the read bank's contents and SHALL be stable from START through exit of RESULT.
REQ-025 WAIT: a cycle counter starts at 0 and increments each cycle; Fft_Done=1 ->RESULT; if the counter reaches TIMEOUT-1 without Fft_Done, the FSM SHALL go ->IDLE, set Fft_Timeout, clear full[read bank], and toggle the read bank (frame aborted, Frame_Count unchanged).
REQ-026 Fft_Done SHALL be ignored in IDLE, START and RESULT.
REQ-027 RESULT: Res_Valid=1 until Res_Ack=1; on that cycle Res_Valid is still 1, and the FSM goes ->IDLE, clears full[read bank], toggles the read bank, and increments Frame_Count (8-bit, 255 wraps to 0).
REQ-028 A bank freed at edge N SHALL make Sample_Ready high from cycle N+1 if it is the write bank.
REQ-029 A write to one bank and a free of the other bank on the same edge SHALL both take effect.
REQ-030 Clr_Flags SHALL clear both sticky flags; a set condition on the same cycle SHALL take priority (flag stays 1).

Reset
REQ-031 Rst_n low SHALL immediately, asynchronously force: FSM=IDLE; both full flags, pointers, indices, and the WAIT counter =0; Fft_Start=0; Res_Valid=0; Frame_Count=0; Overrun=0; Fft_Timeout=0; Sample_Ready=1.
REQ-032 Sample bank contents need not be reset; a partial frame or in-flight FFT at reset SHALL be discarded.

Verification
REQ-033 8 consecutive valid samples 1..8 -> Fft_Start is pulsed the next cycle with Fft_X X0=1 ... X7=8; Fft_Done 3 cycles later -> Res_Valid the next cycle; Res_Ack -> Frame_Count=1.
REQ-034 Stream 24 samples, no Fft_Done -> after 16 samples Sample_Ready=0, 17th sample dropped, Overrun=1; after TIMEOUT cycles Fft_Timeout=1 and Sample_Ready returns to 1.
REQ-035 Hold Res_Ack low 20 cycles while streaming -> second bank fills, Fft_X unchanged, Res_Valid stays 1; ack -> Fft_Start for second frame 2 cycles later.
REQ-036 Fft_Done pulsed in IDLE and in START -> no Res_Valid; Clr_Flags concurrent with a new overrun -> Overrun stays 1.
REQ-037 Rst_n low mid-WAIT with 3 samples buffered -> all outputs at reset values; after release, 8 new samples produce one frame containing only the new samples.
REQ-038 256 acknowledged frames -> Frame_Count wraps to 0.
